// File: rtl/traffic_phase_controller_pkg.sv
// Shared types and constants for the two-road intersection phase controller.
package traffic_pkg;

    localparam int unsigned SEC_W = 7;

    // Phase encoding, also presented on the phase debug output
    typedef enum logic [2:0] {
        S_ALLRED_A  = 3'd0,
        S_NS_GREEN  = 3'd1,
        S_NS_YELLOW = 3'd2,
        S_ALLRED_B  = 3'd3,
        S_EW_GREEN  = 3'd4,
        S_EW_YELLOW = 3'd5,
        S_PED_WALK  = 3'd6,
        S_FLASH     = 3'd7
    } state_e;

    // Lamp codes, {R,Y,G}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Returns {ns_light, ew_light} for a phase; flash_ph selects the lit half in S_FLASH
    function automatic logic [5:0] lamp_decode(input state_e s, input logic flash_ph);
        logic [5:0] l;
        l = {LAMP_R, LAMP_R};
        case (s)
            S_NS_GREEN:  l = {LAMP_G, LAMP_R};
            S_NS_YELLOW: l = {LAMP_Y, LAMP_R};
            S_EW_GREEN:  l = {LAMP_R, LAMP_G};
            S_EW_YELLOW: l = {LAMP_R, LAMP_Y};
            S_FLASH:     l = flash_ph ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
            default:     l = {LAMP_R, LAMP_R};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_timer.sv
// Loadable seconds down-counter that times each phase; holds at zero.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [SEC_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [SEC_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [SEC_W-1:0] count_o,
    output logic             zero_o
);

    logic [SEC_W-1:0] count_q;
    logic [SEC_W-1:0] count_d;

    // Load has priority over decrement; decrement stops at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection sequencer: timed NS/EW phases, pedestrian walk, flash mode.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned pGREEN_NS = 30,
    parameter int unsigned pGREEN_EW = 25,
    parameter int unsigned pYELLOW   = 3,
    parameter int unsigned pALLRED   = 2,
    parameter int unsigned pWALK     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             ped_req,
    input  logic             flash_mode,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             ped_walk,
    output logic [SEC_W-1:0] remaining,
    output logic [2:0]       phase
);

    localparam logic [SEC_W-1:0] D_GREEN_NS = SEC_W'(pGREEN_NS - 1);
    localparam logic [SEC_W-1:0] D_GREEN_EW = SEC_W'(pGREEN_EW - 1);
    localparam logic [SEC_W-1:0] D_YELLOW   = SEC_W'(pYELLOW - 1);
    localparam logic [SEC_W-1:0] D_ALLRED   = SEC_W'(pALLRED - 1);
    localparam logic [SEC_W-1:0] D_WALK     = SEC_W'(pWALK - 1);

    state_e           state_q, state_d;
    logic             ped_pending_q, ped_pending_d;
    logic             flash_ph_q, flash_ph_d;
    logic [2:0]       ns_q, ns_d;
    logic [2:0]       ew_q, ew_d;
    logic             walk_q, walk_d;
    logic             t_load;
    logic [SEC_W-1:0] t_load_val;
    logic             t_zero;
    logic [SEC_W-1:0] t_count;

    // Load value (duration minus one) for a phase
    function automatic logic [SEC_W-1:0] dur_m1(input state_e s);
        logic [SEC_W-1:0] d;
        case (s)
            S_NS_GREEN:  d = D_GREEN_NS;
            S_EW_GREEN:  d = D_GREEN_EW;
            S_NS_YELLOW,
            S_EW_YELLOW: d = D_YELLOW;
            S_PED_WALK:  d = D_WALK;
            S_FLASH:     d = '0;
            default:     d = D_ALLRED;
        endcase
        return d;
    endfunction

    // Normal phase ring; the walk phase is inserted only when a request is pending
    function automatic state_e seq_next(input state_e s, input logic pend);
        state_e n;
        case (s)
            S_ALLRED_A:  n = S_NS_GREEN;
            S_NS_GREEN:  n = S_NS_YELLOW;
            S_NS_YELLOW: n = S_ALLRED_B;
            S_ALLRED_B:  n = S_EW_GREEN;
            S_EW_GREEN:  n = S_EW_YELLOW;
            S_EW_YELLOW: n = pend ? S_PED_WALK : S_ALLRED_A;
            default:     n = S_ALLRED_A;
        endcase
        return n;
    endfunction

    phase_timer #(
        .RST_VAL (D_ALLRED)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .load_val_i (t_load_val),
        .dec_i      (tick & en),
        .count_o    (t_count),
        .zero_o     (t_zero)
    );

    // Next state, timer load, pedestrian latch and lamp decode
    always_comb begin
        state_d       = state_q;
        flash_ph_d    = flash_ph_q;
        ped_pending_d = ped_pending_q;
        t_load        = 1'b0;
        t_load_val    = D_ALLRED;

        if (!en) begin
            state_d    = S_ALLRED_A;
            t_load     = 1'b1;
            t_load_val = D_ALLRED;
            flash_ph_d = 1'b0;
        end else if (tick) begin
            if (flash_mode) begin
                state_d    = S_FLASH;
                t_load     = 1'b1;
                t_load_val = '0;
                flash_ph_d = ~flash_ph_q;
            end else if (state_q == S_FLASH) begin
                state_d    = S_ALLRED_A;
                t_load     = 1'b1;
                t_load_val = D_ALLRED;
                flash_ph_d = 1'b0;
            end else if (t_zero) begin
                state_d    = seq_next(state_q, ped_pending_q);
                t_load     = 1'b1;
                t_load_val = dur_m1(state_d);
            end
        end

        // Set after clear: a request coinciding with walk entry is kept for the next round
        if ((state_d == S_PED_WALK) && (state_q != S_PED_WALK)) begin
            ped_pending_d = 1'b0;
        end
        if (ped_req && (state_q != S_PED_WALK)) begin
            ped_pending_d = 1'b1;
        end

        {ns_d, ew_d} = lamp_decode(state_d, flash_ph_d);
        walk_d       = (state_d == S_PED_WALK);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_ALLRED_A;
            ped_pending_q <= 1'b0;
            flash_ph_q    <= 1'b0;
            ns_q          <= LAMP_R;
            ew_q          <= LAMP_R;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            flash_ph_q    <= flash_ph_d;
            ns_q          <= ns_d;
            ew_q          <= ew_d;
            walk_q        <= walk_d;
        end
    end

    assign ns_light  = ns_q;
    assign ew_light  = ew_q;
    assign ped_walk  = walk_q;
    assign remaining = t_count;
    assign phase     = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios then random stimulus against a reference model.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic [6:0] remaining;
    logic [2:0] phase;

    int vectors = 0;
    int miscompares = 0;

    traffic_phase_controller #(
        .pGREEN_NS (30),
        .pGREEN_EW (25),
        .pYELLOW   (3),
        .pALLRED   (2),
        .pWALK     (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .en         (en),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ped_walk   (ped_walk),
        .remaining  (remaining),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // Reference model: phases numbered in display order 0..6 around the ring, 7 = flash
    int dur  [0:6] = '{2, 30, 3, 2, 25, 3, 10};
    int ns_t [0:6] = '{4, 1, 2, 4, 4, 4, 4};
    int ew_t [0:6] = '{4, 4, 4, 4, 1, 2, 4};
    int m_st, m_rem, m_pend, m_fph;

    task automatic model_reset();
        m_st = 0; m_rem = dur[0] - 1; m_pend = 0; m_fph = 0;
    endtask

    task automatic model_step(input bit t, input bit e, input bit p, input bit f);
        int old;
        old = m_st;
        if (!e) begin
            m_st = 0; m_rem = dur[0] - 1; m_fph = 0;
        end else if (t) begin
            if (f) begin
                m_st = 7; m_rem = 0; m_fph = 1 - m_fph;
            end else if (m_st == 7) begin
                m_st = 0; m_rem = dur[0] - 1; m_fph = 0;
            end else if (m_rem == 0) begin
                if (m_st == 5)      m_st = m_pend ? 6 : 0;
                else if (m_st == 6) m_st = 0;
                else                m_st = m_st + 1;
                m_rem = dur[m_st] - 1;
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (m_st == 6 && old != 6) m_pend = 0;
        if (p && old != 6) m_pend = 1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        int ens, eew;
        if (m_st == 7) begin
            ens = m_fph ? 2 : 0; eew = ens;
        end else begin
            ens = ns_t[m_st]; eew = ew_t[m_st];
        end
        chk("phase", 8'(phase), 8'(m_st));
        chk("remaining", 8'(remaining), 8'(m_rem));
        chk("ns_light", 8'(ns_light), 8'(ens));
        chk("ew_light", 8'(ew_light), 8'(eew));
        chk("ped_walk", 8'(ped_walk), 8'(m_st == 6));
    endtask

    task automatic step(input bit t, input bit e, input bit p, input bit f);
        tick = t; en = e; ped_req = p; flash_mode = f;
        @(posedge clk);
        model_step(t, e, p, f);
        #1;
        compare_model();
        tick = 1'b0; ped_req = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit fl;
        // Power-up reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", 8'(phase), 8'd0);
        chk("rst_rem", 8'(remaining), 8'd1);
        chk("rst_ns", 8'(ns_light), 8'd4);
        chk("rst_ew", 8'(ew_light), 8'd4);
        chk("rst_walk", 8'(ped_walk), 8'd0);
        rst = 1'b0;

        // Full cycle without pedestrian
        tick_n(64);
        chk("cyc64_phase", 8'(phase), 8'd5);
        chk("cyc64_rem", 8'(remaining), 8'd0);
        tick_n(1);
        chk("cyc65_phase", 8'(phase), 8'd0);
        chk("cyc65_rem", 8'(remaining), 8'd1);

        // Pedestrian request during NS green
        tick_n(2);
        chk("nsg_rem", 8'(remaining), 8'd29);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        tick_n(63);
        chk("walk_phase", 8'(phase), 8'd6);
        chk("walk_rem", 8'(remaining), 8'd9);
        chk("walk_lamp", 8'(ped_walk), 8'd1);
        tick_n(9);
        chk("walk_last", 8'(phase), 8'd6);
        tick_n(1);
        chk("walk_exit", 8'(phase), 8'd0);
        chk("walk_exit_lamp", 8'(ped_walk), 8'd0);

        // Request coinciding with walk entry is served next round
        tick_n(2);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        tick_n(62);
        chk("pre_walk_phase", 8'(phase), 8'd5);
        chk("pre_walk_rem", 8'(remaining), 8'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("walk2_phase", 8'(phase), 8'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(10);
        tick_n(65);
        chk("walk3_phase", 8'(phase), 8'd6);
        tick_n(10);
        chk("walk3_exit", 8'(phase), 8'd0);

        // Flash at tick 12 of NS green
        tick_n(2);
        tick_n(11);
        chk("pre_flash_rem", 8'(remaining), 8'd18);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("flash_phase", 8'(phase), 8'd7);
        chk("flash_rem", 8'(remaining), 8'd0);
        chk("flash_on", 8'(ns_light), 8'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("flash_off", 8'(ew_light), 8'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("flash_on2", 8'(ew_light), 8'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("flash_rel_phase", 8'(phase), 8'd0);
        chk("flash_rel_rem", 8'(remaining), 8'd1);

        // Enable dropped mid EW green
        tick_n(37);
        chk("ewg_entry_rem", 8'(remaining), 8'd24);
        tick_n(7);
        chk("ewg_rem", 8'(remaining), 8'd17);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("en0_phase", 8'(phase), 8'd0);
        chk("en0_rem", 8'(remaining), 8'd1);
        chk("en0_ew", 8'(ew_light), 8'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("en1_rem", 8'(remaining), 8'd0);

        // Asynchronous reset mid NS green
        tick_n(5);
        chk("pre_rst_phase", 8'(phase), 8'd1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_phase", 8'(phase), 8'd0);
        chk("arst_rem", 8'(remaining), 8'd1);
        @(posedge clk);
        #1;
        compare_model();
        rst = 1'b0;

        // Random stimulus
        fl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) fl = ~fl;
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) != 0),
                 1'($urandom_range(0, 19) == 0),
                 fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
